// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C target. Oversamples SCL/SDA on CLK, detects
// START/STOP, receives an 8-bit address plus any number of data bytes, ACKs a
// matching address and every data byte, and presents each byte as RX_DATA with
// a one-cycle RX_VALID pulse.
// Build option: define I2C_MSB_FIRST_EN to shift bits MSB first (standard I2C
// order); the default build shifts LSB first to match the team master writer.
module i2c_slave_rx #(
  parameter logic [7:0] SLAVE_ADDR  = 8'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             sr_q, sr_d;
  logic                   done_q, done_d;
  logic                   pend_q, pend_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic                   oe_q, oe_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, scl_high;
  logic start_det, stop_det;
  logic mid_byte;
  logic [7:0] sr_shift;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  // SCL must be high in both samples, so an SCL edge always wins over an SDA change.
  assign scl_high = scl_s & scl_hist_q;
  // Conditions are masked while we pull SDA low so our own ACK cannot look like START/STOP.
  assign start_det = scl_high & sda_hist_q & ~sda_s & ~oe_q;
  assign stop_det  = scl_high & ~sda_hist_q & sda_s & ~oe_q;

  // The SCL rise that opens a STOP/START slot is sampled as a bit before SDA moves;
  // a count of one with that rise still pending (no fall yet) is a clean boundary.
  assign mid_byte = ((state_q == ADDR) || (state_q == DATA)) &&
                    (cnt_q != 3'd0) && !((cnt_q == 3'd1) && pend_q);

`ifdef I2C_MSB_FIRST_EN
  assign sr_shift = {sr_q[6:0], sda_s};
`else
  assign sr_shift = {sda_s, sr_q[7:1]};
`endif

  assign SDA      = oe_q ? 1'b0 : 1'bz;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

  // Input synchronisers plus one history flop per line for edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], SCL};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], SDA};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
  end

  // Receive FSM: bit shifting, byte completion, ACK drive and bus-condition handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    done_d     = 1'b0;
    pend_d     = pend_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    err_d      = err_q;
    oe_d       = oe_q;
    if (scl_fall) pend_d = 1'b0;
    if (stop_det) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
      pend_d  = 1'b0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      if (mid_byte) err_d = 1'b1;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      pend_d  = 1'b0;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      err_d   = mid_byte;
    end else begin
      case (state_q)
        ADDR, DATA: begin
          if (done_q) begin
            if (state_q == ADDR) begin
              state_d = (sr_q == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
            end else begin
              rx_data_d  = sr_q;
              rx_valid_d = 1'b1;
              state_d    = DATA_ACK;
            end
          end else if (scl_rise) begin
            sr_d   = sr_shift;
            cnt_d  = cnt_q + 3'd1;
            pend_d = 1'b1;
            done_d = (cnt_q == 3'd7);
          end
        end
        ADDR_ACK, DATA_ACK: begin
          // First fall (end of bit 8) starts the ACK, second fall (end of bit 9) ends it.
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              busy_d  = 1'b1;
              state_d = DATA;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State register with synchronous active-low reset; reset releases SDA at once.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      sr_q       <= 8'h00;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      oe_q       <= oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: directed bench for i2c_slave_rx. Acts as I2C master on an
// open-drain SDA with pull-up; bit order follows I2C_MSB_FIRST_EN like the DUT.
module tb_i2c_slave_rx;

  localparam int Q = 4;  // quarter SCL period in CLKs (SCL period = 16 CLKs)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  // Monitor state (written only by the monitor process)
  int         valid_cnt = 0;
  logic [7:0] last_valid_data = 8'h00;
  logic [7:0] prev_valid_data = 8'h00;
  int         dut_low_cnt = 0;
  int         rise_age = 0;
  int         last_latency = -1;
  logic       scl_mon = 1'b1;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .CLK     (clk),
    .RST_N   (rst_n),
    .SCL     (scl),
    .SDA     (sda),
    .RX_DATA (rx_data),
    .RX_VALID(rx_valid),
    .BUSY    (busy),
    .ERR     (err)
  );

  // Negedge monitor: valid pulses, their latency from the last SCL rise, DUT-driven SDA lows
  always @(negedge clk) begin
    if (scl && !scl_mon) rise_age = 0;
    else rise_age = rise_age + 1;
    scl_mon = scl;
    if (rx_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      prev_valid_data = last_valid_data;
      last_valid_data = rx_data;
      last_latency = rise_age;
    end
    if (!sda_low && sda === 1'b0) dut_low_cnt = dut_low_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic i2c_start();
    sda_low = 1'b0; tick(Q);
    scl = 1'b1;     tick(Q);
    sda_low = 1'b1; tick(Q);
    scl = 1'b0;     tick(Q);
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1; tick(Q);
    scl = 1'b1;     tick(Q);
    sda_low = 1'b0; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; tick(Q);
    scl = 1'b1;   tick(2*Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
`ifdef I2C_MSB_FIRST_EN
      send_bit(b[7-i]);
`else
      send_bit(b[i]);
`endif
    end
  endtask

  task automatic ack_slot(output logic acked);
    sda_low = 1'b0; tick(Q);
    scl = 1'b1;     tick(Q);
    acked = (sda === 1'b0);
    tick(Q);
    scl = 1'b0;     tick(Q);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(4);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda: got %b expected 1 (released)", sda); end
    rst_n = 1'b1; tick(4);
    $display("test_reset: rx_data=%h busy=%b err=%b sda=%b", rx_data, busy, err, sda);
  endtask

  task automatic test_single_byte();
    int   v0;
    logic a1, a2;
    v0 = valid_cnt;
    i2c_start();
    send_byte(8'h50); ack_slot(a1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_high: got %b expected 1", busy); end
    send_byte(8'hA5); ack_slot(a2);
    i2c_stop(); tick(Q);
    checks++; if (a1 !== 1'b1) begin errors++; $display("FAIL single_addr_ack: got %b expected 1", a1); end
    checks++; if (a2 !== 1'b1) begin errors++; $display("FAIL single_data_ack: got %b expected 1", a2); end
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL single_valid_pulses: got %0d expected 1", valid_cnt - v0); end
    checks++; if (last_valid_data !== 8'hA5) begin errors++; $display("FAIL single_valid_data: got %h expected a5", last_valid_data); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL single_rx_data: got %h expected a5", rx_data); end
    checks++; if (last_latency != 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", last_latency); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_low: got %b expected 0", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b expected 0", err); end
    $display("test_single_byte: acks=%b%b rx_data=%h latency=%0d busy=%b", a1, a2, rx_data, last_latency, busy);
  endtask

  task automatic test_addr_mismatch();
    int   v0, l0;
    logic a1, a2;
    v0 = valid_cnt; l0 = dut_low_cnt;
    i2c_start();
    send_byte(8'h51); ack_slot(a1);
    send_byte(8'h5A); ack_slot(a2);
    i2c_stop(); tick(Q);
    checks++; if (a1 !== 1'b0) begin errors++; $display("FAIL mismatch_addr_ack: got %b expected 0", a1); end
    checks++; if (a2 !== 1'b0) begin errors++; $display("FAIL mismatch_data_ack: got %b expected 0", a2); end
    checks++; if (dut_low_cnt != l0) begin errors++; $display("FAIL mismatch_sda_driven: got %0d cycles expected 0", dut_low_cnt - l0); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL mismatch_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mismatch_busy: got %b expected 0", busy); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL mismatch_rx_hold: got %h expected a5", rx_data); end
    $display("test_addr_mismatch: acks=%b%b rx_data=%h busy=%b", a1, a2, rx_data, busy);
  endtask

  task automatic test_multi_byte();
    int   v0;
    logic a1, a2, a3;
    v0 = valid_cnt;
    i2c_start();
    send_byte(8'h50); ack_slot(a1);
    send_byte(8'h3C); ack_slot(a2);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL multi_first_byte: got %h expected 3c", rx_data); end
    send_byte(8'hC3); ack_slot(a3);
    i2c_stop(); tick(Q);
    checks++; if ({a1, a2, a3} !== 3'b111) begin errors++; $display("FAIL multi_acks: got %b expected 111", {a1, a2, a3}); end
    checks++; if (valid_cnt - v0 != 2) begin errors++; $display("FAIL multi_valid_pulses: got %0d expected 2", valid_cnt - v0); end
    checks++; if ({prev_valid_data, last_valid_data} !== 16'h3CC3) begin errors++; $display("FAIL multi_sequence: got %h expected 3cc3", {prev_valid_data, last_valid_data}); end
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL multi_rx_data: got %h expected c3", rx_data); end
    $display("test_multi_byte: acks=%b%b%b seq=%h,%h", a1, a2, a3, prev_valid_data, last_valid_data);
  endtask

  task automatic test_partial_byte();
    int   v0;
    logic a1;
    v0 = valid_cnt;
    i2c_start();
    send_byte(8'h50); ack_slot(a1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop(); tick(Q);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL partial_err: got %b expected 1", err); end
    checks++; if (valid_cnt != v0) begin errors++; $display("FAIL partial_valid: got %0d expected 0", valid_cnt - v0); end
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL partial_rx_hold: got %h expected c3", rx_data); end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL partial_sda: got %b expected 1 (released)", sda); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy: got %b expected 0", busy); end
    // Next START clears the sticky error; a clean STOP right after leaves it clear.
    i2c_start();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL partial_err_cleared: got %b expected 0", err); end
    i2c_stop(); tick(Q);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clean_stop_err: got %b expected 0", err); end
    $display("test_partial_byte: ack=%b rx_data=%h err_after_clear=%b", a1, rx_data, err);
  endtask

  task automatic test_reset_in_ack();
    logic a1;
    i2c_start();
    send_byte(8'h50); ack_slot(a1);
    send_byte(8'h77);
    sda_low = 1'b0; tick(1);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rstack_driving: got %b expected 0", sda); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstack_busy_before: got %b expected 1", busy); end
    checks++; if (rx_data !== 8'h77) begin errors++; $display("FAIL rstack_rx_before: got %h expected 77", rx_data); end
    rst_n = 1'b0; tick(1);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rstack_sda_released: got %b expected 1", sda); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstack_rx_data: got %h expected 00", rx_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstack_busy: got %b expected 0", busy); end
    checks++; if ({rx_valid, err} !== 2'b00) begin errors++; $display("FAIL rstack_valid_err: got %b expected 00", {rx_valid, err}); end
    rst_n = 1'b1; tick(2);
    i2c_stop(); tick(Q);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rstack_idle_stop_err: got %b expected 0", err); end
    $display("test_reset_in_ack: ack=%b sda=%b rx_data=%h busy=%b", a1, sda, rx_data, busy);
  endtask

  task automatic test_data_01();
    logic a1, a2;
    i2c_start();
    send_byte(8'h50); ack_slot(a1);
    send_byte(8'h01); ack_slot(a2);
    i2c_stop(); tick(Q);
    checks++; if ({a1, a2} !== 2'b11) begin errors++; $display("FAIL d01_acks: got %b expected 11", {a1, a2}); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL d01_rx_data: got %h expected 01", rx_data); end
    $display("test_data_01: acks=%b%b rx_data=%h", a1, a2, rx_data);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_addr_mismatch();
    test_multi_byte();
    test_partial_byte();
    test_reset_in_ack();
    test_data_01();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
